sa_aw_arbiter: RTL and testbench

SA_AW_ARBITER -- requirements
Module: sa_aw_arbiter

---
 rtl/sa_aw_arbiter_pkg.sv | 20 ++
 rtl/sa_aw_arbiter_if.sv | 36 +++
 rtl/sa_rr_selector.sv | 41 ++++
 rtl/sa_aw_arbiter.sv | 123 ++++++++++++
 tb/tb_sa_aw_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_aw_arbiter_pkg.sv
// Shared interconnect definitions for the AW arbiter and the WDATA channel.
// Holds the default geometry, the ID-width helper and the AW issue-slot state type.
package sa_aw_arbiter_pkg;

  // A single master still needs a 1-bit ID so that no port collapses to zero width.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MST_AMT_DEF          = 3;
  localparam int MST_ID_W_DEF         = id_width(MST_AMT_DEF);
  localparam int ADDR_WIDTH_DEF       = 32;
  localparam int TRANS_DATA_LEN_W_DEF = 3;

  typedef enum logic {
    AW_IDLE = 1'b0,
    AW_BUSY = 1'b1
  } aw_state_e;

endpackage

// File: rtl/sa_aw_arbiter_if.sv
// Bundle of the dispatcher-side, slave-side and order-FIFO signals of one AW arbiter.
// The master modport is the environment around the arbiter; slave is the arbiter's view.
interface sa_aw_arbiter_if #(
  parameter int MST_AMT          = sa_aw_arbiter_pkg::MST_AMT_DEF,
  parameter int MST_ID_W         = sa_aw_arbiter_pkg::id_width(MST_AMT),
  parameter int ADDR_WIDTH       = sa_aw_arbiter_pkg::ADDR_WIDTH_DEF,
  parameter int TRANS_DATA_LEN_W = sa_aw_arbiter_pkg::TRANS_DATA_LEN_W_DEF
);

  logic [ADDR_WIDTH*MST_AMT-1:0]       dsp_awaddr;
  logic [TRANS_DATA_LEN_W*MST_AMT-1:0] dsp_awlen;
  logic [MST_AMT-1:0]                  dsp_awvalid;
  logic [MST_AMT-1:0]                  dsp_slv_sel;
  logic [MST_AMT-1:0]                  dsp_awready;

  logic [ADDR_WIDTH-1:0]               s_awaddr;
  logic [TRANS_DATA_LEN_W-1:0]         s_awlen;
  logic                                s_awvalid;
  logic                                s_awready;

  logic [MST_ID_W-1:0]                 mst_id;
  logic [TRANS_DATA_LEN_W-1:0]         axlen;
  logic                                order_wr_en;
  logic                                aw_stall;

  modport master (
    output dsp_awaddr, dsp_awlen, dsp_awvalid, dsp_slv_sel, s_awready, aw_stall,
    input  dsp_awready, s_awaddr, s_awlen, s_awvalid, mst_id, axlen, order_wr_en
  );

  modport slave (
    input  dsp_awaddr, dsp_awlen, dsp_awvalid, dsp_slv_sel, s_awready, aw_stall,
    output dsp_awready, s_awaddr, s_awlen, s_awvalid, mst_id, axlen, order_wr_en
  );

endinterface

// File: rtl/sa_rr_selector.sv
// Round-robin winner search: first requesting index at or after ptr, wrapping to 0.
// Produces a one-hot grant and its encoded index; both are zero when nothing requests.
module sa_rr_selector #(
  parameter int N    = 3,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] id
);

  logic [N-1:0] upper;
  logic [N-1:0] pick;

  // Requests at or above the pointer have priority; if none, the wrap-around
  // search reduces to the lowest requester overall.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    upper = '0;
    for (int i = 0; i < N; i++) begin
      upper[i] = req[i] && (ID_W'(i) >= ptr);
    end
  end

  assign pick = (|upper) ? upper : req;

  // Descending scan: the last hit written is the lowest set bit of pick.
  always_comb begin
    grant = '0;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        id       = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/sa_aw_arbiter.sv
// Per-slave AW arbiter: round-robin among dispatcher masters, single-entry AW issue
// slot with back-to-back refill, and same-cycle push of (ID, AWLEN) to the WDATA order FIFO.
module sa_aw_arbiter
  import sa_aw_arbiter_pkg::*;
#(
  parameter int MST_AMT          = MST_AMT_DEF,
  parameter int MST_ID_W         = id_width(MST_AMT),
  parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF,
  parameter int TRANS_DATA_LEN_W = TRANS_DATA_LEN_W_DEF
) (
  input  logic                                ACLK_i,
  input  logic                                ARESETn_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]       dsp_AWADDR_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0] dsp_AWLEN_i,
  input  logic [MST_AMT-1:0]                  dsp_AWVALID_i,
  input  logic [MST_AMT-1:0]                  dsp_slv_sel_i,
  output logic [MST_AMT-1:0]                  dsp_AWREADY_o,
  output logic [ADDR_WIDTH-1:0]               s_AWADDR_o,
  output logic [TRANS_DATA_LEN_W-1:0]         s_AWLEN_o,
  output logic                                s_AWVALID_o,
  input  logic                                s_AWREADY_i,
  output logic [MST_ID_W-1:0]                 AW_mst_id_o,
  output logic [TRANS_DATA_LEN_W-1:0]         AW_AxLEN_o,
  output logic                                AW_fifo_order_wr_en_o,
  input  logic                                AW_stall_i
);

  logic [MST_AMT-1:0]          req;
  logic [MST_AMT-1:0]          win_onehot;
  logic [MST_ID_W-1:0]         win_id;
  logic [MST_ID_W-1:0]         next_ptr;
  logic [MST_ID_W-1:0]         rr_ptr;
  logic [MST_ID_W-1:0]         id_q;
  logic [ADDR_WIDTH-1:0]       win_addr;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [TRANS_DATA_LEN_W-1:0] win_len;
  logic [TRANS_DATA_LEN_W-1:0] len_q;
  logic                        slot_free;
  logic                        grant_en;
  logic                        handshake;
  aw_state_e                   state_q;
  aw_state_e                   state_d;

  assign req       = dsp_AWVALID_i & dsp_slv_sel_i;
  assign slot_free = ~s_AWVALID_o | s_AWREADY_i;
  assign handshake = s_AWVALID_o & s_AWREADY_i;

  // Gating with ARESETn_i keeps ready and the FIFO strobe low while reset is held.
  assign grant_en  = ARESETn_i & slot_free & ~AW_stall_i & (|req);

  sa_rr_selector #(
    .N    (MST_AMT),
    .ID_W (MST_ID_W)
  ) u_rr_selector (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (win_onehot),
    .id    (win_id)
  );

  // Winner payload as an AND-OR mux over the one-hot grant.
  always_comb begin
    win_addr = '0;
    win_len  = '0;
    for (int m = 0; m < MST_AMT; m++) begin
      if (win_onehot[m]) begin
        win_addr = dsp_AWADDR_i[ADDR_WIDTH*m +: ADDR_WIDTH];
        win_len  = dsp_AWLEN_i[TRANS_DATA_LEN_W*m +: TRANS_DATA_LEN_W];
      end
    end
  end

  assign dsp_AWREADY_o         = grant_en ? win_onehot : '0;
  assign AW_fifo_order_wr_en_o = grant_en;
  assign AW_mst_id_o           = win_id;
  assign AW_AxLEN_o            = win_len;

  assign next_ptr = (win_id == MST_ID_W'(MST_AMT - 1)) ? '0 : win_id + MST_ID_W'(1);

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      state_q <= AW_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      AW_IDLE: if (grant_en) state_d = AW_BUSY;
      AW_BUSY: if (handshake && !grant_en) state_d = AW_IDLE;
      default: state_d = AW_IDLE;
    endcase
  end

  assign s_AWVALID_o = (state_q == AW_BUSY);

  // Payload only moves on a grant, which cannot happen while the slot is stalled.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      addr_q <= '0;
      len_q  <= '0;
      id_q   <= '0;
      rr_ptr <= '0;
    end else if (grant_en) begin
      addr_q <= win_addr;
      len_q  <= win_len;
      id_q   <= win_id;
      rr_ptr <= next_ptr;
    end
  end

  assign s_AWADDR_o = addr_q;
  assign s_AWLEN_o  = len_q;

  aw_payload_stable_a: assert property (
    @(posedge ACLK_i) disable iff (!ARESETn_i)
    (s_AWVALID_o && !s_AWREADY_i) |=> ($stable(s_AWADDR_o) && $stable(s_AWLEN_o) && $stable(id_q))
  );

endmodule

// File: tb/tb_sa_aw_arbiter.sv
// Bench for sa_aw_arbiter: directed scenarios plus randomized traffic checked
// against a round-robin issue-slot model kept in plain procedural code.
module tb_sa_aw_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int LW = 3;
  localparam int IW = 2;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  sa_aw_arbiter_if #(.MST_AMT(N), .MST_ID_W(IW), .ADDR_WIDTH(AW), .TRANS_DATA_LEN_W(LW)) aw ();

  sa_aw_arbiter #(.MST_AMT(N), .MST_ID_W(IW), .ADDR_WIDTH(AW), .TRANS_DATA_LEN_W(LW)) dut (
    .ACLK_i                (aclk),
    .ARESETn_i             (aresetn),
    .dsp_AWADDR_i          (aw.dsp_awaddr),
    .dsp_AWLEN_i           (aw.dsp_awlen),
    .dsp_AWVALID_i         (aw.dsp_awvalid),
    .dsp_slv_sel_i         (aw.dsp_slv_sel),
    .dsp_AWREADY_o         (aw.dsp_awready),
    .s_AWADDR_o            (aw.s_awaddr),
    .s_AWLEN_o             (aw.s_awlen),
    .s_AWVALID_o           (aw.s_awvalid),
    .s_AWREADY_i           (aw.s_awready),
    .AW_mst_id_o           (aw.mst_id),
    .AW_AxLEN_o            (aw.axlen),
    .AW_fifo_order_wr_en_o (aw.order_wr_en),
    .AW_stall_i            (aw.aw_stall)
  );

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] t_addr [N];
  logic [LW-1:0] t_len  [N];
  logic [N-1:0]  t_valid;
  logic [N-1:0]  t_sel;

  int            m_ptr;
  bit            m_valid;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;

  logic [N-1:0]  e_ready;
  bit            e_grant;
  int            e_win;

  task automatic drive();
    aw.dsp_awaddr  = {t_addr[2], t_addr[1], t_addr[0]};
    aw.dsp_awlen   = {t_len[2], t_len[1], t_len[0]};
    aw.dsp_awvalid = t_valid;
    aw.dsp_slv_sel = t_sel;
  endtask

  task automatic clear_masters();
    for (int m = 0; m < N; m++) begin
      t_addr[m] = '0;
      t_len[m]  = '0;
    end
    t_valid = '0;
    t_sel   = '0;
    drive();
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 0;
    m_addr  = '0;
    m_len   = '0;
  endtask

  // One AW slot: a master may be accepted when the slot is empty or draining this cycle.
  task automatic model_eval();
    logic [N-1:0] r;
    r       = aw.dsp_awvalid & aw.dsp_slv_sel;
    e_grant = aresetn && (!m_valid || aw.s_awready) && !aw.aw_stall && (r != '0);
    e_win   = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (e_win < 0 && ((r >> idx) & 1) != 0) e_win = idx;
    end
    e_ready = e_grant ? (N'(1) << e_win) : '0;
  endtask

  // Advances one clock: model sees the same inputs the DUT samples at the edge.
  task automatic tick();
    model_eval();
    @(posedge aclk);
    if (aresetn) begin
      if (e_grant) begin
        m_valid = 1;
        m_addr  = t_addr[e_win];
        m_len   = t_len[e_win];
        m_ptr   = (e_win + 1) % N;
      end else if (m_valid && aw.s_awready) begin
        m_valid = 0;
      end
    end
    @(negedge aclk);
    #1;
  endtask

  task automatic apply_reset();
    aresetn      = 1'b0;
    aw.s_awready = 1'b0;
    aw.aw_stall  = 1'b0;
    clear_masters();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    aresetn      = 1'b0;
    aw.s_awready = 1'b1;
    aw.aw_stall  = 1'b0;
    clear_masters();
    t_valid = 3'b111;
    t_sel   = 3'b111;
    drive();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    #1;
    checks++; if (aw.dsp_awready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", aw.dsp_awready); end
    checks++; if (aw.order_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", aw.order_wr_en); end
    checks++; if (aw.s_awvalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", aw.s_awvalid); end
    checks++; if (aw.s_awaddr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", aw.s_awaddr); end
    checks++; if (aw.s_awlen !== 3'd0) begin errors++; $display("FAIL reset_len: got %0d expected 0", aw.s_awlen); end
    checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", dut.rr_ptr); end
  endtask

  // Reset is released on the same cycle the first request arrives.
  task automatic test_single();
    @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
    clear_masters();
    t_valid[1] = 1'b1;
    t_sel[1]   = 1'b1;
    t_addr[1]  = 32'h100;
    t_len[1]   = 3'd3;
    aw.s_awready = 1'b1;
    drive();
    #1;
    checks++; if (aw.dsp_awready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b expected 010", aw.dsp_awready); end
    checks++; if (aw.order_wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en: got %b expected 1", aw.order_wr_en); end
    checks++; if (aw.mst_id !== 2'd1) begin errors++; $display("FAIL single_id: got %0d expected 1", aw.mst_id); end
    checks++; if (aw.axlen !== 3'd3) begin errors++; $display("FAIL single_axlen: got %0d expected 3", aw.axlen); end
    tick();
    clear_masters();
    #1;
    checks++; if (aw.s_awvalid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", aw.s_awvalid); end
    checks++; if (aw.s_awaddr !== 32'h100) begin errors++; $display("FAIL single_addr: got %h expected 100", aw.s_awaddr); end
    checks++; if (aw.s_awlen !== 3'd3) begin errors++; $display("FAIL single_len: got %0d expected 3", aw.s_awlen); end
    checks++; if (dut.rr_ptr !== 2'd2) begin errors++; $display("FAIL single_ptr: got %0d expected 2", dut.rr_ptr); end
    tick();
    #1;
    checks++; if (aw.s_awvalid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", aw.s_awvalid); end
  endtask

  task automatic test_back_to_back();
    int order [4] = '{0, 1, 2, 0};
    apply_reset();
    for (int m = 0; m < N; m++) begin
      t_addr[m] = 32'h1000 + 32'(m) * 32'h10;
      t_len[m]  = LW'(m + 1);
    end
    t_valid      = 3'b111;
    t_sel        = 3'b111;
    aw.s_awready = 1'b1;
    drive();
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (aw.dsp_awready !== (3'b001 << order[c])) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected winner %0d", c, aw.dsp_awready, order[c]); end
      checks++; if (aw.mst_id !== IW'(order[c]) || aw.order_wr_en !== 1'b1) begin errors++; $display("FAIL b2b_push[%0d]: got id %0d wr_en %b expected id %0d wr_en 1", c, aw.mst_id, aw.order_wr_en, order[c]); end
      if (c > 0) begin
        checks++; if (aw.s_awvalid !== 1'b1 || aw.s_awaddr !== t_addr[order[c-1]]) begin errors++; $display("FAIL b2b_issue[%0d]: got valid %b addr %h expected valid 1 addr %h", c, aw.s_awvalid, aw.s_awaddr, t_addr[order[c-1]]); end
      end
      tick();
    end
    #1;
    checks++; if (aw.s_awvalid !== 1'b1 || aw.s_awaddr !== 32'h1000) begin errors++; $display("FAIL b2b_last: got valid %b addr %h expected valid 1 addr 1000", aw.s_awvalid, aw.s_awaddr); end
    clear_masters();
  endtask

  task automatic test_backpressure();
    apply_reset();
    t_valid[0] = 1'b1; t_sel[0] = 1'b1; t_addr[0] = 32'h200; t_len[0] = 3'd5;
    aw.s_awready = 1'b1;
    drive();
    #1;
    tick();
    aw.s_awready = 1'b0;
    t_valid[0] = 1'b0;
    t_valid[2] = 1'b1; t_sel[2] = 1'b1; t_addr[2] = 32'h300; t_len[2] = 3'd2;
    drive();
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (aw.dsp_awready !== 3'b000 || aw.order_wr_en !== 1'b0) begin errors++; $display("FAIL bp_no_grant[%0d]: got ready %b wr_en %b expected 000 0", c, aw.dsp_awready, aw.order_wr_en); end
      checks++; if (aw.s_awvalid !== 1'b1 || aw.s_awaddr !== 32'h200 || aw.s_awlen !== 3'd5) begin errors++; $display("FAIL bp_hold[%0d]: got valid %b addr %h len %0d expected 1 200 5", c, aw.s_awvalid, aw.s_awaddr, aw.s_awlen); end
      tick();
    end
    aw.s_awready = 1'b1;
    #1;
    checks++; if (aw.dsp_awready !== 3'b100 || aw.order_wr_en !== 1'b1 || aw.mst_id !== 2'd2) begin errors++; $display("FAIL bp_release: got ready %b wr_en %b id %0d expected 100 1 2", aw.dsp_awready, aw.order_wr_en, aw.mst_id); end
    tick();
    #1;
    checks++; if (aw.s_awvalid !== 1'b1 || aw.s_awaddr !== 32'h300) begin errors++; $display("FAIL bp_next: got valid %b addr %h expected 1 300", aw.s_awvalid, aw.s_awaddr); end
  endtask

  // Continues from the backpressure scenario with master 2's AW pending.
  task automatic test_stall();
    aw.aw_stall = 1'b1;
    t_addr[2] = 32'h340;
    t_len[2]  = 3'd7;
    drive();
    #1;
    checks++; if (aw.dsp_awready !== 3'b000 || aw.order_wr_en !== 1'b0) begin errors++; $display("FAIL stall_block: got ready %b wr_en %b expected 000 0", aw.dsp_awready, aw.order_wr_en); end
    tick();
    #1;
    checks++; if (aw.s_awvalid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b expected 0", aw.s_awvalid); end
    checks++; if (aw.dsp_awready !== 3'b000) begin errors++; $display("FAIL stall_idle: got %b expected 000", aw.dsp_awready); end
    tick();
    aw.aw_stall = 1'b0;
    #1;
    checks++; if (aw.dsp_awready !== 3'b100 || aw.order_wr_en !== 1'b1 || aw.axlen !== 3'd7) begin errors++; $display("FAIL stall_release: got ready %b wr_en %b len %0d expected 100 1 7", aw.dsp_awready, aw.order_wr_en, aw.axlen); end
    tick();
    #1;
    checks++; if (aw.s_awvalid !== 1'b1 || aw.s_awaddr !== 32'h340) begin errors++; $display("FAIL stall_issue: got valid %b addr %h expected 1 340", aw.s_awvalid, aw.s_awaddr); end
    clear_masters();
  endtask

  task automatic test_unselected();
    apply_reset();
    t_valid[0] = 1'b1; t_sel[0] = 1'b0; t_addr[0] = 32'h55;
    aw.s_awready = 1'b1;
    drive();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (aw.dsp_awready !== 3'b000 || aw.order_wr_en !== 1'b0 || aw.s_awvalid !== 1'b0) begin errors++; $display("FAIL unsel[%0d]: got ready %b wr_en %b valid %b expected 000 0 0", c, aw.dsp_awready, aw.order_wr_en, aw.s_awvalid); end
      tick();
    end
    clear_masters();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < N; m++) begin
        t_addr[m] = $urandom;
        t_len[m]  = LW'($urandom);
      end
      t_valid      = N'($urandom);
      t_sel        = N'($urandom) | N'($urandom);
      aw.s_awready = ($urandom_range(0, 3) != 0);
      aw.aw_stall  = ($urandom_range(0, 4) == 0);
      drive();
      #1;
      model_eval();
      checks++; if (aw.dsp_awready !== e_ready || aw.order_wr_en !== e_grant) begin errors++; $display("FAIL rand_grant[%0d]: got ready %b wr_en %b expected %b %b", c, aw.dsp_awready, aw.order_wr_en, e_ready, e_grant); end
      if (e_grant) begin
        checks++; if (aw.mst_id !== IW'(e_win) || aw.axlen !== t_len[e_win]) begin errors++; $display("FAIL rand_push[%0d]: got id %0d len %0d expected %0d %0d", c, aw.mst_id, aw.axlen, e_win, t_len[e_win]); end
      end
      checks++; if (aw.s_awvalid !== m_valid || aw.s_awaddr !== m_addr || aw.s_awlen !== m_len) begin errors++; $display("FAIL rand_slot[%0d]: got valid %b addr %h len %0d expected %b %h %0d", c, aw.s_awvalid, aw.s_awaddr, aw.s_awlen, m_valid, m_addr, m_len); end
      checks++; if (dut.rr_ptr !== IW'(m_ptr)) begin errors++; $display("FAIL rand_ptr[%0d]: got %0d expected %0d", c, dut.rr_ptr, m_ptr); end
      tick();
    end
    aw.aw_stall = 1'b0;
    clear_masters();
  endtask

  task automatic test_async_reset();
    apply_reset();
    t_valid[1] = 1'b1; t_sel[1] = 1'b1; t_addr[1] = 32'h180; t_len[1] = 3'd4;
    aw.s_awready = 1'b0;
    drive();
    #1;
    tick();
    clear_masters();
    #1;
    checks++; if (aw.s_awvalid !== 1'b1 || dut.rr_ptr !== 2'd2) begin errors++; $display("FAIL arst_pre: got valid %b ptr %0d expected 1 2", aw.s_awvalid, dut.rr_ptr); end
    #1;
    aresetn = 1'b0;
    #1;
    checks++; if (aw.s_awvalid !== 1'b0 || dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL arst_now: got valid %b ptr %0d expected 0 0", aw.s_awvalid, dut.rr_ptr); end
    checks++; if (aw.s_awaddr !== 32'h0 || aw.s_awlen !== 3'd0) begin errors++; $display("FAIL arst_payload: got addr %h len %0d expected 0 0", aw.s_awaddr, aw.s_awlen); end
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_stall();
    test_unselected();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
